// File: rtl/wb_sram_pkg.sv
// wb_sram_pkg: shared types and helpers for the Wishbone SRAM slave.
//   state_e     - response FSM states
//   size_e      - access size derived from the Wishbone byte select
//   sel_to_size - byte select to access size decode
package wb_sram_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_BAD  = 2'd3
  } size_e;

  // The size is the number of selected lanes. A two-lane select must name
  // adjacent lanes, otherwise it does not describe a halfword and is
  // rejected (e.g. 4'b0101).
  function automatic size_e sel_to_size(input logic [3:0] sel);
    case (sel)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: return SZ_BYTE;
      4'b0011, 4'b0110, 4'b1100:          return SZ_HALF;
      4'b1111:                            return SZ_WORD;
      default:                            return SZ_BAD;
    endcase
  endfunction

endpackage

// File: rtl/wb_sram_array.sv
// wb_sram_array: single-port 32-bit word storage with per-byte write
// enables and a registered (synchronous) read. Kept behind this boundary so
// a compiled SRAM macro can be dropped in. Contents are never reset.
// Ports:
//   clk   - clock, rising edge
//   en    - access enable; read data is captured only when en=1
//   be    - byte write enables (lane i = bits [8i+7:8i])
//   addr  - word address
//   wdata - write data, already lane-aligned
//   rdata - word read at the last enabled edge (value before any write)
module wb_sram_array #(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          en,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  localparam int DEPTH = 1 << AW;

  logic [31:0] mem [DEPTH];
  logic [31:0] rdata_q;
  logic [31:0] rdata_d;

  always_comb begin
    rdata_d = rdata_q;
    if (en) begin
      rdata_d = mem[addr];
    end
  end

  always_ff @(posedge clk) begin
    rdata_q <= rdata_d;
    if (en) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/wb_sram.sv
// wb_sram: Wishbone classic slave in front of a byte-writable SRAM.
// Writes commit at the accept edge and ack one cycle later; reads capture
// the word at the accept edge, wait WAIT_STATES cycles, then ack. Illegal
// size/alignment or out-of-range addresses produce an err pulse instead.
// Ports:
//   clk, rst_n          - clock (rising edge), synchronous active-low reset
//   wb_cyc_i, wb_stb_i  - Wishbone cycle / strobe
//   wb_we_i             - 1 = write, 0 = read
//   wb_sel_i            - byte select; lane count gives the access size
//   wb_adr_i, wb_dat_i  - byte address, right-aligned write data
//   wb_dat_o            - right-aligned read data, valid only with wb_ack_o
//   wb_ack_o, wb_err_o  - one-cycle completion / error pulses
//   busy_o              - FSM is not idle
module wb_sram
  import wb_sram_pkg::*;
#(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_STATES = 0,
  parameter int CHECK_RANGE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_sel_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic        busy_o
);

  localparam int CNT_W = (WAIT_STATES == 0) ? 1 : $clog2(WAIT_STATES + 1);
  localparam logic [CNT_W-1:0] WAIT_LAST =
    CNT_W'((WAIT_STATES == 0) ? 0 : WAIT_STATES - 1);
  // Any address bit at or above ADDR_WIDTH lies outside the array.
  localparam logic [31:0] HI_MASK = ~((32'h1 << ADDR_WIDTH) - 32'h1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [1:0]       sh_q, sh_d;

  size_e       req_size;
  logic [3:0]  lane_be;
  logic        misalign;
  logic        out_of_range;
  logic        req_err;
  logic        mem_en;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  // Request decode: lanes come from the address, the size from the select.
  always_comb begin
    req_size = sel_to_size(wb_sel_i);
    lane_be  = 4'b0000;
    misalign = 1'b1;
    case (req_size)
      SZ_BYTE: begin
        lane_be  = 4'b0001 << wb_adr_i[1:0];
        misalign = 1'b0;
      end
      SZ_HALF: begin
        lane_be  = wb_adr_i[1] ? 4'b1100 : 4'b0011;
        misalign = wb_adr_i[0];
      end
      SZ_WORD: begin
        lane_be  = 4'b1111;
        misalign = |wb_adr_i[1:0];
      end
      default: begin
        lane_be  = 4'b0000;
        misalign = 1'b1;
      end
    endcase
    out_of_range = (CHECK_RANGE != 0) && (|(wb_adr_i & HI_MASK));
    req_err      = misalign || out_of_range;
  end

  assign mem_wdata = wb_dat_i << {wb_adr_i[1:0], 3'b000};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    sh_d    = sh_q;
    mem_en  = 1'b0;
    mem_be  = 4'b0000;
    case (state_q)
      IDLE: begin
        // Gated by rst_n so nothing is committed on an edge that resets.
        if (wb_cyc_i && wb_stb_i && rst_n) begin
          sh_d  = wb_adr_i[1:0];
          err_d = req_err;
          cnt_d = '0;
          if (req_err) begin
            state_d = RESP;
          end else if (wb_we_i) begin
            mem_en  = 1'b1;
            mem_be  = lane_be;
            state_d = RESP;
          end else begin
            mem_en  = 1'b1;
            state_d = (WAIT_STATES == 0) ? RESP : WAIT;
          end
        end
      end
      WAIT: begin
        if (!wb_cyc_i) begin
          state_d = IDLE;
        end else if (cnt_q == WAIT_LAST) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
    sh_q <= sh_d;
  end

  wb_sram_array #(
    .AW (ADDR_WIDTH - 2)
  ) u_array (
    .clk   (clk),
    .en    (mem_en),
    .be    (mem_be),
    .addr  (wb_adr_i[ADDR_WIDTH-1:2]),
    .wdata (mem_wdata),
    .rdata (mem_rdata)
  );

  // The array only re-reads on an accept, so its output is stable for the
  // whole RESP cycle.
  assign wb_ack_o = (state_q == RESP) && !err_q;
  assign wb_err_o = (state_q == RESP) && err_q;
  assign busy_o   = (state_q != IDLE);
  assign wb_dat_o = wb_ack_o ? (mem_rdata >> {sh_q, 3'b000}) : 32'h0;

endmodule

// File: tb/tb_wb_sram.sv
module tb_wb_sram;

  localparam int WS = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_cyc_i, wb_stb_i, wb_we_i;
  logic [3:0]  wb_sel_i;
  logic [31:0] wb_adr_i, wb_dat_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o, wb_err_o, busy_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_sram #(
    .ADDR_WIDTH  (10),
    .WAIT_STATES (WS),
    .CHECK_RANGE (1)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wb_cyc_i (wb_cyc_i),
    .wb_stb_i (wb_stb_i),
    .wb_we_i  (wb_we_i),
    .wb_sel_i (wb_sel_i),
    .wb_adr_i (wb_adr_i),
    .wb_dat_i (wb_dat_i),
    .wb_dat_o (wb_dat_o),
    .wb_ack_o (wb_ack_o),
    .wb_err_o (wb_err_o),
    .busy_o   (busy_o)
  );

  // Issues one request; inputs are scrambled right after the accept edge so
  // every transaction also shows that the slave latched what it needed.
  task automatic do_req(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                        input logic [31:0] dat, output int lat, output logic ack,
                        output logic err, output logic [31:0] rdat,
                        output logic ack_next, output logic err_next);
    @(posedge clk); #1;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
    wb_adr_i = adr;  wb_sel_i = sel;  wb_dat_i = dat;
    @(posedge clk); #1;
    wb_stb_i = 1'b0; wb_we_i = ~we;
    wb_adr_i = 32'hFFFF_FFFF; wb_sel_i = 4'b0101; wb_dat_i = 32'h5A5A_5A5A;
    lat = 1;
    while (!(wb_ack_o || wb_err_o) && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    ack = wb_ack_o; err = wb_err_o; rdat = wb_dat_o;
    @(posedge clk); #1;
    ack_next = wb_ack_o; err_next = wb_err_o;
    wb_cyc_i = 1'b0; wb_we_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (wb_ack_o !== 1'b0) begin errors++; $display("FAIL rst_ack: got %b expected 0", wb_ack_o); end
    checks++; if (wb_err_o !== 1'b0) begin errors++; $display("FAIL rst_err: got %b expected 0", wb_err_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy_o); end
    checks++; if (wb_dat_o !== 32'h0) begin errors++; $display("FAIL rst_dat: got %h expected 00000000", wb_dat_o); end
    rst_n = 1'b1;
  endtask

  task automatic test_word_rw();
    int lat; logic ack, err, an, en; logic [31:0] rd;
    do_req(1'b1, 32'h10, 4'b1111, 32'hDEADBEEF, lat, ack, err, rd, an, en);
    checks++; if (lat !== 1) begin errors++; $display("FAIL wr_lat: got %0d expected 1", lat); end
    checks++; if (ack !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL wr_resp: ack=%b err=%b expected ack=1 err=0", ack, err); end
    checks++; if (an !== 1'b0 || en !== 1'b0) begin errors++; $display("FAIL wr_pulse: ack=%b err=%b next cycle expected 0 0", an, en); end
    do_req(1'b0, 32'h10, 4'b1111, 32'h0, lat, ack, err, rd, an, en);
    checks++; if (lat !== 1 + WS) begin errors++; $display("FAIL rd_lat: got %0d expected %0d", lat, 1 + WS); end
    checks++; if (ack !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL rd_resp: ack=%b err=%b expected ack=1 err=0", ack, err); end
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_word: got %h expected deadbeef", rd); end
    checks++; if (an !== 1'b0) begin errors++; $display("FAIL rd_pulse: ack next cycle %b expected 0", an); end
  endtask

  task automatic test_byte_half();
    int lat; logic ack, err, an, en; logic [31:0] rd;
    do_req(1'b1, 32'h10, 4'b1111, 32'h0, lat, ack, err, rd, an, en);
    do_req(1'b1, 32'h13, 4'b0001, 32'hA5, lat, ack, err, rd, an, en);
    checks++; if (lat !== 1 || ack !== 1'b1) begin errors++; $display("FAIL wr_byte: lat=%0d ack=%b expected 1 1", lat, ack); end
    do_req(1'b0, 32'h10, 4'b1111, 32'h0, lat, ack, err, rd, an, en);
    checks++; if (rd !== 32'hA5000000) begin errors++; $display("FAIL rd_after_byte: got %h expected a5000000", rd); end
    do_req(1'b0, 32'h13, 4'b0001, 32'h0, lat, ack, err, rd, an, en);
    checks++; if (rd !== 32'h000000A5) begin errors++; $display("FAIL rd_byte3: got %h expected 000000a5", rd); end
    do_req(1'b1, 32'h10, 4'b0011, 32'hBEEF, lat, ack, err, rd, an, en);
    checks++; if (ack !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL wr_half: ack=%b err=%b expected 1 0", ack, err); end
    do_req(1'b0, 32'h10, 4'b1111, 32'h0, lat, ack, err, rd, an, en);
    checks++; if (rd !== 32'hA500BEEF) begin errors++; $display("FAIL rd_after_half: got %h expected a500beef", rd); end
    do_req(1'b0, 32'h12, 4'b0011, 32'h0, lat, ack, err, rd, an, en);
    checks++; if (rd !== 32'h0000A500) begin errors++; $display("FAIL rd_half_hi: got %h expected 0000a500", rd); end
  endtask

  task automatic test_errors();
    int lat; logic ack, err, an, en; logic [31:0] rd;
    do_req(1'b1, 32'h11, 4'b0011, 32'h1234, lat, ack, err, rd, an, en);
    checks++; if (lat !== 1 || err !== 1'b1 || ack !== 1'b0) begin errors++; $display("FAIL err_half_odd: lat=%0d ack=%b err=%b expected 1 0 1", lat, ack, err); end
    checks++; if (en !== 1'b0) begin errors++; $display("FAIL err_pulse: err next cycle %b expected 0", en); end
    do_req(1'b1, 32'h10, 4'b0101, 32'hFFFF, lat, ack, err, rd, an, en);
    checks++; if (err !== 1'b1 || ack !== 1'b0) begin errors++; $display("FAIL err_sel0101: ack=%b err=%b expected 0 1", ack, err); end
    do_req(1'b1, 32'h10, 4'b0111, 32'hFFFFFF, lat, ack, err, rd, an, en);
    checks++; if (err !== 1'b1 || ack !== 1'b0) begin errors++; $display("FAIL err_sel0111: ack=%b err=%b expected 0 1", ack, err); end
    do_req(1'b0, 32'h12, 4'b1111, 32'h0, lat, ack, err, rd, an, en);
    checks++; if (lat !== 1 || err !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL err_word_misalign: lat=%0d err=%b dat=%h expected 1 1 00000000", lat, err, rd); end
    do_req(1'b0, 32'h10, 4'b1111, 32'h0, lat, ack, err, rd, an, en);
    checks++; if (rd !== 32'hA500BEEF) begin errors++; $display("FAIL err_no_write: got %h expected a500beef", rd); end
  endtask

  task automatic test_range();
    int lat; logic ack, err, an, en; logic [31:0] rd;
    do_req(1'b1, 32'h000, 4'b1111, 32'h0, lat, ack, err, rd, an, en);
    do_req(1'b1, 32'h400, 4'b1111, 32'hFFFFFFFF, lat, ack, err, rd, an, en);
    checks++; if (err !== 1'b1 || ack !== 1'b0) begin errors++; $display("FAIL range_err: ack=%b err=%b expected 0 1", ack, err); end
    do_req(1'b0, 32'h000, 4'b1111, 32'h0, lat, ack, err, rd, an, en);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL range_alias: word0 got %h expected 00000000", rd); end
    do_req(1'b1, 32'h3FC, 4'b1111, 32'h13579BDF, lat, ack, err, rd, an, en);
    do_req(1'b0, 32'h3FC, 4'b1111, 32'h0, lat, ack, err, rd, an, en);
    checks++; if (ack !== 1'b1 || rd !== 32'h13579BDF) begin errors++; $display("FAIL range_top: ack=%b dat=%h expected 1 13579bdf", ack, rd); end
  endtask

  task automatic test_abort();
    int lat; logic ack, err, an, en; logic [31:0] rd; logic seen;
    @(posedge clk); #1;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 32'h10; wb_sel_i = 4'b1111;
    @(posedge clk); #1;                     // accepted, first WAIT cycle
    wb_stb_i = 1'b0;
    @(posedge clk); #1;                     // second WAIT cycle
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL abort_busy_wait: got %b expected 1", busy_o); end
    wb_cyc_i = 1'b0;
    @(posedge clk); #1;
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL abort_busy_low: got %b expected 0", busy_o); end
    seen = wb_ack_o | wb_err_o;
    repeat (4) begin @(posedge clk); #1; seen |= wb_ack_o | wb_err_o; end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL abort_resp: ack/err seen=%b expected 0", seen); end
    do_req(1'b0, 32'h10, 4'b1111, 32'h0, lat, ack, err, rd, an, en);
    checks++; if (lat !== 1 + WS || rd !== 32'hA500BEEF) begin errors++; $display("FAIL abort_next_rd: lat=%0d dat=%h expected %0d a500beef", lat, rd, 1 + WS); end
  endtask

  task automatic test_reset_mid();
    int lat; logic ack, err, an, en; logic [31:0] rd; logic seen;
    @(posedge clk); #1;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 32'h10; wb_sel_i = 4'b1111;
    @(posedge clk); #1;                     // accepted
    wb_stb_i = 1'b0; rst_n = 1'b0;
    @(posedge clk); #1;
    checks++; if (busy_o !== 1'b0 || wb_ack_o !== 1'b0 || wb_err_o !== 1'b0 || wb_dat_o !== 32'h0) begin
      errors++; $display("FAIL midrst_outs: busy=%b ack=%b err=%b dat=%h expected all 0", busy_o, wb_ack_o, wb_err_o, wb_dat_o);
    end
    rst_n = 1'b1; wb_cyc_i = 1'b0;
    seen = 1'b0;
    repeat (5) begin @(posedge clk); #1; seen |= wb_ack_o | wb_err_o; end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL midrst_resp: ack/err seen=%b expected 0", seen); end
    do_req(1'b0, 32'h10, 4'b1111, 32'h0, lat, ack, err, rd, an, en);
    checks++; if (ack !== 1'b1 || rd !== 32'hA500BEEF) begin errors++; $display("FAIL midrst_mem: ack=%b dat=%h expected 1 a500beef", ack, rd); end
  endtask

  initial begin
    rst_n = 1'b0; wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    wb_sel_i = 4'b0; wb_adr_i = 32'h0; wb_dat_i = 32'h0;
    test_reset();
    test_word_rw();
    test_byte_half();
    test_errors();
    test_range();
    test_abort();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
